power_scheduler: RTL
====================

# power_scheduler

Shares the solar array's power output among the airflow, thrusters and solar-tracking components. Each component raises a request with a power cost; the scheduler grants requests round-robin while the committed total fits the available budget, and sheds holders when the sun is lost. It sits in `control` beside the three component instances and is clocked from the same tick.

## Interface
- `MAX_BUDGET`, default 120: power units available while `sun_on`=1.
- `RESERVE`, default 40: power units available while `sun_on`=0 (battery).
- `BUDGET_W`, default 8: width of costs and budget.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: scheduler enable.
- `sun_on` in 1: solar producing power.
- `req` in 3: per-requester request; bit0 airflow, bit1 thrusters, bit2 solar.
- `cost` in 3*BUDGET_W: per-requester cost, flattened; requester i occupies [i*BUDGET_W +: BUDGET_W].
- `done` in 3: holder releases its grant.
- `grant` out 3: grant mask; multiple bits may be high.
- `shed` out 3: one-cycle pulse when a grant is revoked.
- `budget` out BUDGET_W: available power minus committed power.
- `state` out 2: FSM state.

## Operation
- Available power: `avail` = `sun_on` ? `MAX_BUDGET` : `RESERVE`.
- Committed power: `alloc` = sum of the costs latched for all holders. `alloc` is BUDGET_W+2 bits wide and never wraps.
- Latched cost: captured at grant time. Later changes on `cost` are ignored while the grant is held.
- States:
  - `S_OFF` (2'b00):
    - `grant`=0.
    - `en`=1 → `S_RUN`.
  - `S_RUN` (2'b01):
    - First apply releases: any `done[i]` with `grant[i]`=1 clears `grant[i]`.
    - If `alloc` > `avail` after releases → `S_SHED`.
    - Otherwise grant at most one new requester.
      - Eligible: `req[i]`=1, `grant[i]`=0, and latched cost ≤ `avail` − `alloc`.
      - Search order is round-robin, starting at pointer `rr`.
      - After a grant, `rr` = grantee+1 mod 3.
      - Ineligible requesters are skipped. `rr` does not move when nothing is granted.
  - `S_SHED` (2'b10):
    - Revoke one holder per cycle, highest index first (solar, thrusters, airflow).
    - `shed[i]` pulses on the same cycle `grant[i]` clears.
    - When `alloc` ≤ `avail`, return to `S_RUN`. No new grants are made while in `S_SHED`.
  - 2'b11: unused; decodes to `S_OFF`.
- `en`=0 in any state: next edge clears all grants, `shed`=0, and the FSM enters `S_OFF`.
- `done[i]` without `grant[i]` is ignored.
- `req` dropped before grant is ignored. `req` held while granted has no effect.
- Cost 0: grantable at any time; consumes no budget.
- A cost greater than `avail` is never granted. This does not block other requesters.

## Timing
- Reset values (`rst`=0, immediate): `grant`=0, `shed`=0, `budget`=0, `state`=`S_OFF`, `rr`=0.
- Grant latency: `req` sampled at edge k, so `grant` is high after edge k.
- Release: `done` at edge k clears `grant` at edge k. Freed power is usable by a grant at that same edge k.
- `budget` is registered. It reflects the post-edge `alloc` and `avail`, saturates at 0, and reads 0 in `S_OFF`.
- `sun_on` falling with `alloc` > `RESERVE`:
  - `S_SHED` is entered at the next edge.
  - The first `shed` pulse comes one edge later.
- `rst` asserted mid-grant or mid-shed: all outputs return to reset values asynchronously, with no `shed` pulse.

## Configuration
- `POWER_SCHED_AIRFLOW_PRIORITY_EN`, when defined:
  - Airflow is exempt from round-robin: whenever it is eligible, it is granted ahead of the others.
  - Airflow is never shed, even if `alloc` stays above `avail`. `S_SHED` exits once only airflow holds.
- When undefined: airflow is treated identically to the other requesters.

## Test plan
- Contention: defaults, `en`=1, `sun_on`=1, `req`=3'b111, costs 50/50/50 → `grant` 3'b001, then 3'b011; solar is never granted; `budget`=20.
- Release plus grant: from the previous state, `done[0]`=1 for one cycle → next edge `grant`=3'b110, `budget`=20.
- Shedding: holders thrusters+solar (cost 50 each), `sun_on`→0 → `S_SHED`; `shed`=3'b100, then 3'b010; `grant`=0, `budget`=40, `S_RUN`.
- Async reset: assert `rst`=0 between edges while `grant`=3'b011 → `grant`=0, `state`=0 immediately; `en`=1 after release → first grant follows the `rr`=0 order.
- Oversize and zero cost: solar cost 130, thrusters cost 0 → solar is never granted; thrusters are granted with `budget` unchanged at 120.
- Macro: with `POWER_SCHED_AIRFLOW_PRIORITY_EN` defined, airflow 60 + thrusters 50 held, `sun_on`→0 → only `shed[1]` pulses; airflow stays granted; `budget`=0.

Source files
------------

// File: rtl/power_scheduler.sv
// Round-robin power budget scheduler for airflow, thrusters and solar tracking.
// Optional macro POWER_SCHED_AIRFLOW_PRIORITY_EN gives airflow strict priority and shed immunity.
module power_scheduler #(
    parameter int MAX_BUDGET = 120,
    parameter int RESERVE    = 40,
    parameter int BUDGET_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sun_on,
    input  logic [2:0]            req,
    input  logic [3*BUDGET_W-1:0] cost,
    input  logic [2:0]            done,
    output logic [2:0]            grant,
    output logic [2:0]            shed,
    output logic [BUDGET_W-1:0]   budget,
    output logic [1:0]            state
);

    localparam int AW = BUDGET_W + 2;

`ifdef POWER_SCHED_AIRFLOW_PRIORITY_EN
    localparam logic [2:0] SHED_MASK = 3'b110;
`else
    localparam logic [2:0] SHED_MASK = 3'b111;
`endif

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_RUN  = 2'b01,
        S_SHED = 2'b10
    } state_t;

    state_t                         state_q, state_d;
    logic [2:0]                     grant_q, grant_d;
    logic [2:0]                     shed_q, shed_d;
    logic [BUDGET_W-1:0]            budget_q, budget_d;
    logic [1:0]                     rr_q, rr_d;
    logic [2:0][BUDGET_W-1:0]       lat_q, lat_d;

    logic [AW-1:0] avail;
    logic [AW-1:0] alloc_rel;
    logic [AW-1:0] alloc_post;
    logic [AW-1:0] free_pwr;
    logic [2:0]    held;
    logic          found;
    logic [1:0]    pick;
    logic [1:0]    victim;

    // Committed power of a holder set, using the costs latched at grant time.
    function automatic logic [AW-1:0] sum_held(input logic [2:0] g,
                                               input logic [2:0][BUDGET_W-1:0] c);
        logic [AW-1:0] s;
        s = '0;
        for (int i = 0; i < 3; i++) begin
            if (g[i]) s = s + AW'(c[i]);
        end
        return s;
    endfunction

    assign avail = sun_on ? AW'(MAX_BUDGET) : AW'(RESERVE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_OFF;
            grant_q  <= '0;
            shed_q   <= '0;
            budget_q <= '0;
            rr_q     <= '0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            shed_q   <= shed_d;
            budget_q <= budget_d;
            rr_q     <= rr_d;
            lat_q    <= lat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        shed_d     = '0;
        rr_d       = rr_q;
        lat_d      = lat_q;
        found      = 1'b0;
        pick       = 2'd0;
        victim     = 2'd0;
        alloc_post = '0;
        held       = grant_q & ~done;
        alloc_rel  = sum_held(held, lat_q);
        free_pwr   = (alloc_rel > avail) ? '0 : (avail - alloc_rel);

        case (state_q)
            S_OFF: begin
                grant_d = '0;
                if (en) state_d = S_RUN;
            end
            S_RUN: begin
                grant_d = held;
                if ((alloc_rel > avail) && |(held & SHED_MASK)) begin
                    state_d = S_SHED;
                end else begin
`ifdef POWER_SCHED_AIRFLOW_PRIORITY_EN
                    if (req[0] && !held[0] && (AW'(cost[0 +: BUDGET_W]) <= free_pwr)) begin
                        found = 1'b1;
                        pick  = 2'd0;
                    end
`endif
                    // Search starts at the pointer; the pointer only advances past a grantee.
                    for (int k = 0; k < 3; k++) begin
                        int j;
                        j = (int'(rr_q) + k) % 3;
                        if (!found && req[j] && !held[j] &&
                            (AW'(cost[j*BUDGET_W +: BUDGET_W]) <= free_pwr)) begin
                            found = 1'b1;
                            pick  = 2'(j);
                            rr_d  = 2'((j + 1) % 3);
                        end
                    end
                    if (found) begin
                        grant_d[pick] = 1'b1;
                        lat_d[pick]   = cost[pick*BUDGET_W +: BUDGET_W];
                    end
                end
            end
            S_SHED: begin
                grant_d = held;
                if ((alloc_rel <= avail) || !(|(held & SHED_MASK))) begin
                    state_d = S_RUN;
                end else begin
                    if (held[2] && SHED_MASK[2])      victim = 2'd2;
                    else if (held[1] && SHED_MASK[1]) victim = 2'd1;
                    else                              victim = 2'd0;
                    grant_d[victim] = 1'b0;
                    shed_d[victim]  = 1'b1;
                    alloc_post = sum_held(grant_d, lat_q);
                    if ((alloc_post <= avail) || !(|(grant_d & SHED_MASK))) state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_OFF;
                grant_d = '0;
            end
        endcase

        if (!en) begin
            state_d = S_OFF;
            grant_d = '0;
            shed_d  = '0;
        end
    end

    // Headroom after this edge, clamped at zero and forced to zero while off.
    always_comb begin
        logic [AW-1:0] committed;
        committed = sum_held(grant_d, lat_d);
        if (state_d == S_OFF || committed > avail) budget_d = '0;
        else                                        budget_d = BUDGET_W'(avail - committed);
    end

    always_comb begin
        grant  = grant_q;
        shed   = shed_q;
        budget = budget_q;
        state  = state_q;
    end

endmodule
